// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the index scan sequencer.
package scan_seq_pkg;

   // Width of the decoder select index (4-to-16 decoder).
   localparam int IDX_W = 4;

   // Sequencer states.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : scan_seq_pkg

// File: rtl/scan_seq_if.sv
// Control/status bundle between a scan requester and the scan sequencer.
// Handshake: start is a level that the sequencer samples every cycle while
// idle (no ready/acknowledge). busy acts as the acceptance indication: it
// rises one cycle after start is taken. done and wrap are single-cycle
// pulses with no back-pressure.
interface scan_seq_if #(
   parameter int DWELL_W = 8
);
   import scan_seq_pkg::*;

   // Requester -> sequencer
   logic               start;
   logic               stop;
   logic               mode;
   logic [IDX_W-1:0]   first;
   logic [IDX_W-1:0]   last;
   logic [DWELL_W-1:0] dwell;

   // Sequencer -> decoder / requester
   logic               e;
   logic [IDX_W-1:0]   i;
   logic               busy;
   logic               done;
   logic               wrap;

   modport master (
      output start, stop, mode, first, last, dwell,
      input  e, i, busy, done, wrap
   );

   modport slave (
      input  start, stop, mode, first, last, dwell,
      output e, i, busy, done, wrap
   );

endinterface : scan_seq_if

// File: rtl/scan_seq_dwell_cnt.sv
// Per-index dwell down-counter with load, decrement and zero flag.
module dwell_cnt #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               dec_i,
   input  logic [DWELL_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   // Load wins over decrement; the counter saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule : dwell_cnt

// File: rtl/scan_seq.sv
// Scan sequencer: steps a decoder index from first to last (mod 16),
// holding each index dwell+1 cycles, in single-pass or continuous mode.
module scan_seq
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   scan_seq_if.slave   bus,
   output state_e      dbg_state_o
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   i_q, i_d;
   logic               e_q, e_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;

   // Scan configuration captured when a scan is accepted.
   logic [IDX_W-1:0]   first_q, last_q;
   logic               mode_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               cfg_latch;

   logic               cnt_load, cnt_dec, cnt_zero;
   logic [DWELL_W-1:0] cnt_val;

   logic               accept;
   logic               at_last;

   assign accept  = bus.start && !bus.stop;
   assign at_last = (i_q == last_q);

   dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: stop beats start in IDLE and beats any advance in RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (cnt_zero && at_last && !mode_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and counter control for the next cycle.
   always_comb begin
      i_d       = i_q;
      e_d       = (state_d == RUN);
      done_d    = 1'b0;
      wrap_d    = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = dwell_q;
      cfg_latch = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cfg_latch = 1'b1;
               i_d       = bus.first;
               cnt_load  = 1'b1;
               cnt_val   = bus.dwell;
            end
         end
         RUN: begin
            if (!bus.stop) begin
               if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else if (!at_last) begin
                  // 4-bit add wraps 15 -> 0, so first > last is a valid range.
                  i_d      = i_q + 1'b1;
                  cnt_load = 1'b1;
               end else if (mode_q) begin
                  i_d      = first_q;
                  cnt_load = 1'b1;
                  wrap_d   = 1'b1;
               end else begin
                  done_d   = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and captured configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q     <= '0;
         e_q     <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         first_q <= '0;
         last_q  <= '0;
         mode_q  <= 1'b0;
         dwell_q <= '0;
      end else begin
         i_q    <= i_d;
         e_q    <= e_d;
         done_q <= done_d;
         wrap_q <= wrap_d;
         if (cfg_latch) begin
            first_q <= bus.first;
            last_q  <= bus.last;
            mode_q  <= bus.mode;
            dwell_q <= bus.dwell;
         end
      end
   end

   // e and i drive the decoder directly; busy is the same flop as e.
   assign bus.e       = e_q;
   assign bus.i       = i_q;
   assign bus.busy    = e_q;
   assign bus.done    = done_q;
   assign bus.wrap    = wrap_q;
   assign dbg_state_o = state_q;

endmodule : scan_seq
